// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Holds word/address widths, the FIFO entry struct and the control FSM states.
package fetch_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } fetch_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundles for the fetch unit: blockRAM read port and decode handshake.
// master = fetch unit side, slave = RAM / decode side.
interface fetch_ram_if;
    import fetch_pkg::*;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_dout
    );

    modport slave (
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_dout
    );
endinterface

interface fetch_instr_if;
    import fetch_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with synchronous flush.
// Ports: clock, reset_n, flush, push/din, pop/dout, count, full, empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    assign do_pop  = pop & ~flush & ~empty;
    // A push into a full FIFO is only taken when the head leaves this cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: PC, blockRAM issue, prefetch FIFO, redirect flush.
// Ports: clock, reset_n, fetch_en, redirect_valid/redirect_pc, ram (RAM read
// port, master), instr (decode valid/ready, master), perf_fetched, perf_stalls.
// Optional: define FETCH_PERF_CNT_EN to instantiate the saturating perf counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_ram_if.master       ram,
    fetch_instr_if.master     instr,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic              issue;
    logic              credit;
    logic [CW:0]       used;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    // Slots already promised to a read in flight count as occupied,
    // so a returning word always finds room.
    assign used   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit = (used < (CW+1)'(FIFO_DEPTH)) & ~full;
    assign issue  = reset_n & fetch_en & ~redirect_valid & credit;

    assign ram.ram_en   = issue;
    assign ram.ram_addr = pc;
    assign ram.ram_we   = 1'b0;
    assign ram.ram_di   = '0;

    // A word returning in a redirect cycle belongs to the old stream.
    assign push       = inflight & ~redirect_valid;
    assign push_entry = '{pc: addr_q, data: ram.ram_dout};

    assign instr.instr_valid = ~empty & ~redirect_valid;
    assign instr.instr_data  = empty ? '0 : head.data;
    assign instr.instr_pc    = empty ? '0 : head.pc;
    assign pop               = instr.instr_valid & instr.instr_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                addr_q <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    state_d = ST_FLUSH;
                end else if (fetch_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    state_d = ST_FLUSH;
                end else if (!fetch_en && !inflight) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (redirect_valid) begin
                    state_d = ST_FLUSH;
                end else if (fetch_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= sat_inc(perf_fetched);
            end
            if (instr.instr_valid && !instr.instr_ready) begin
                perf_stalls <= sat_inc(perf_stalls);
            end
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a 1-cycle-latency RAM model.
// Covers reset, streaming, backpressure, redirect flush, PC wrap, mid-op reset.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              fetch_en = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stalls;

    fetch_ram_if   ram_bus ();
    fetch_instr_if ins_bus ();

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    int n_chk  = 0;
    int n_pass = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam int EXP_STALLS  = 6;
    localparam int EXP_FETCHED = 8;
`else
    localparam int EXP_STALLS  = 0;
    localparam int EXP_FETCHED = 0;
`endif

    always #5 clock = ~clock;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ram            (ram_bus),
        .instr          (ins_bus),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
    );

    always @(posedge clock) begin
        if (ram_bus.ram_en) begin
            ram_bus.ram_dout <= mem[ram_bus.ram_addr];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n = 0;
        while (!ins_bus.instr_valid && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(ins_bus.instr_valid), 32'd1);
    endtask

    task automatic check_head(input string tag, input logic [ADDR_W-1:0] pc);
        check({tag, "_v"}, 32'(ins_bus.instr_valid), 32'd1);
        check({tag, "_pc"}, 32'(ins_bus.instr_pc), 32'(pc));
        check({tag, "_d"}, 32'(ins_bus.instr_data), 32'(mem[pc]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_iss;
        int exp_pc;
        int first_iss;
        int n;

        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = DATA_W'(i * 37 + 5);
        end
        mem[2] = 16'd10;
        mem[3] = 16'd15;
        mem[4] = 16'd25;
        ins_bus.instr_ready = 1'b0;

        // reset with fetch_en high
        reset_n  = 1'b0;
        fetch_en = 1'b1;
        step();
        step();
        check("rst_ram_en", 32'(ram_bus.ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_bus.ram_we), 32'd0);
        check("rst_ram_di", 32'(ram_bus.ram_di), 32'd0);
        check("rst_ram_addr", 32'(ram_bus.ram_addr), 32'd0);
        check("rst_valid", 32'(ins_bus.instr_valid), 32'd0);
        check("rst_data", 32'(ins_bus.instr_data), 32'd0);
        check("rst_pc", 32'(ins_bus.instr_pc), 32'd0);
        check("rst_perf_f", perf_fetched, 32'd0);
        check("rst_perf_s", perf_stalls, 32'd0);

        // stream from redirect to 2
        fetch_en = 1'b0;
        reset_n  = 1'b1;
        step();
        check("idle_no_issue", 32'(ram_bus.ram_en), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 10'd2;
        fetch_en = 1'b1;
        ins_bus.instr_ready = 1'b1;
        #1;
        check("redir_no_issue", 32'(ram_bus.ram_en), 32'd0);
        check("redir_no_valid", 32'(ins_bus.instr_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_issue_en", 32'(ram_bus.ram_en), 32'd1);
        check("redir_issue_addr", 32'(ram_bus.ram_addr), 32'd2);
        step();
        step();
        check_head("s0", 10'd2);
        step();
        check_head("s1", 10'd3);
        step();
        check_head("s2", 10'd4);
        fetch_en = 1'b0;
        #1;
        check("stop_no_issue", 32'(ram_bus.ram_en), 32'd0);
        repeat (6) step();
        check("drained", 32'(ins_bus.instr_valid), 32'd0);

        // backpressure
        do_reset();
        fetch_en = 1'b1;
        ins_bus.instr_ready = 1'b0;
        #1;
        n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            if (ram_bus.ram_en) begin
                check($sformatf("bp_addr%0d", n_iss),
                      32'(ram_bus.ram_addr), 32'(n_iss));
                n_iss++;
            end
            step();
        end
        check("bp_issues", 32'(n_iss), 32'd4);
        check("bp_hold", 32'(ram_bus.ram_en), 32'd0);
        check("bp_stalls", perf_stalls, 32'(EXP_STALLS));
        check_head("bp_h0", 10'd0);
        ins_bus.instr_ready = 1'b1;
        #1;
        exp_pc = 0;
        first_iss = -1;
        for (int i = 0; i < 8; i++) begin
            if (ram_bus.ram_en && first_iss < 0) begin
                first_iss = int'(ram_bus.ram_addr);
            end
            if (ins_bus.instr_valid) begin
                check($sformatf("bp_pop%0d", exp_pc),
                      32'(ins_bus.instr_pc), 32'(exp_pc));
                check($sformatf("bp_dat%0d", exp_pc),
                      32'(ins_bus.instr_data), 32'(mem[exp_pc]));
                exp_pc++;
            end
            step();
        end
        check("bp_npop", 32'(exp_pc), 32'd8);
        check("bp_resume", 32'(first_iss), 32'd4);
        check("bp_fetched", perf_fetched, 32'(EXP_FETCHED));
        check("bp_stalls_hold", perf_stalls, 32'(EXP_STALLS));

        // redirect with read of 5 in flight
        do_reset();
        fetch_en = 1'b1;
        ins_bus.instr_ready = 1'b1;
        #1;
        n = 0;
        while (!(ram_bus.ram_en && ram_bus.ram_addr == 10'd5) && n < 20) begin
            step();
            n++;
        end
        check("rd_saw_5", 32'(ram_bus.ram_en && ram_bus.ram_addr == 10'd5), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 10'd100;
        #1;
        check("rd_valid_forced", 32'(ins_bus.instr_valid), 32'd0);
        check("rd_no_issue", 32'(ram_bus.ram_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        wait_valid("rd_wait", 10);
        check_head("rd_h0", 10'd100);
        step();
        check_head("rd_h1", 10'd101);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 10'd1023;
        #1;
        step();
        redirect_valid = 1'b0;
        #1;
        wait_valid("wr_wait", 10);
        check_head("wr_h0", 10'd1023);
        step();
        check_head("wr_h1", 10'd0);
        step();
        check_head("wr_h2", 10'd1);

        // reset mid-operation with 3 entries buffered
        do_reset();
        fetch_en = 1'b1;
        ins_bus.instr_ready = 1'b0;
        #1;
        repeat (4) step();
        check("mr_valid_pre", 32'(ins_bus.instr_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(ins_bus.instr_valid), 32'd0);
        check("mr_ram_en", 32'(ram_bus.ram_en), 32'd0);
        step();
        reset_n = 1'b1;
        ins_bus.instr_ready = 1'b1;
        #1;
        wait_valid("mr_wait", 10);
        check_head("mr_h0", 10'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
